// File: rtl/checker_arbiter_pkg.sv
// Shared definitions for the hashchecker arbiter: FSM state encoding,
// default hash width and a constant-friendly clog2 helper.
package checker_arbiter_pkg;

  localparam int HASH_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    DROP   = 3'd2,
    WAIT   = 3'd3,
    REPLY  = 3'd4
  } arb_state_e;

  // Ceiling log2, never below 1 so every derived vector has at least one bit
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/checker_arbiter_rr_pick.sv
// Round-robin picker: first set request bit after last_served, wrapping,
// so the lane just served is the last one considered.
module checker_arbiter_rr_pick
  import checker_arbiter_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     last_served,
  output logic                 found,
  output logic [IDX_W-1:0]     index
);

  logic [IDX_W-1:0] cand;

  // Walk offsets 1..NUM_LANES from last_served; the nearest requester wins
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = IDX_W'((int'(last_served) + k) % NUM_LANES);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/checker_arbiter.sv
// Shares one hashchecker among NUM_LANES cracking lanes. Lanes are picked
// round-robin; the arbiter strobes checkrdy, waits for resultrdy (with a
// watchdog) and returns the match/timeout result with a one-cycle lane_done.
// Optional statistics counters are built when CHECKER_ARB_STATS_EN is defined.
module checker_arbiter
  import checker_arbiter_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int HASH_W         = HASH_W_DEF,
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        lane_req,
  input  logic [NUM_LANES*HASH_W-1:0] lane_hash,
  output logic [NUM_LANES-1:0]        lane_done,
  output logic                        lane_match,
  output logic                        lane_timeout,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy,
  output logic                        checker_checkrdy,
  output logic [HASH_W-1:0]           checker_hash,
  input  logic                        checker_resultrdy,
  input  logic                        checker_matchfound
`ifdef CHECKER_ARB_STATS_EN
  ,
  output logic [31:0]                 check_count,
  output logic [15:0]                 match_count
`endif
);

  localparam int TMO_W = clog2(TIMEOUT_CYCLES) + 1;
  localparam int STB_W = clog2(STROBE_CYCLES) + 1;

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [HASH_W-1:0]        hash_q, hash_d;
  logic                     match_q, match_d;
  logic                     tflag_q, tflag_d;
  logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0]         stb_cnt_q, stb_cnt_d;

  logic [NUM_LANES-1:0][HASH_W-1:0] hash_arr;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;

  // Same bit layout as lane_hash: lane i occupies [i*HASH_W +: HASH_W]
  assign hash_arr = lane_hash;

  checker_arbiter_rr_pick #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req         (lane_req),
    .last_served (last_q),
    .found       (pick_found),
    .index       (pick_idx)
  );

  // Next-state logic: grant, strobe, ignore stale resultrdy, wait with watchdog, reply
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    hash_d    = hash_q;
    match_d   = match_q;
    tflag_d   = tflag_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          hash_d    = hash_arr[pick_idx];
          tmo_cnt_d = '0;
          stb_cnt_d = '0;
          state_d   = STROBE;
        end
      end
      STROBE: begin
        if (stb_cnt_q == STB_W'(STROBE_CYCLES - 1)) state_d = DROP;
        else stb_cnt_d = stb_cnt_q + 1'b1;
      end
      DROP: state_d = WAIT;
      WAIT: begin
        if (checker_resultrdy) begin
          match_d = checker_matchfound;
          tflag_d = 1'b0;
          state_d = REPLY;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          match_d = 1'b0;
          tflag_d = 1'b1;
          state_d = REPLY;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      REPLY: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= '0;
      hash_q    <= '0;
      match_q   <= 1'b0;
      tflag_q   <= 1'b0;
      tmo_cnt_q <= '0;
      stb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      hash_q    <= hash_d;
      match_q   <= match_d;
      tflag_q   <= tflag_d;
      tmo_cnt_q <= tmo_cnt_d;
      stb_cnt_q <= stb_cnt_d;
    end
  end

  // Outputs decoded from registered state; lane_done pulses only in REPLY
  always_comb begin
    lane_done = '0;
    if (state_q == REPLY) lane_done[grant_q] = 1'b1;
  end

  assign lane_match       = match_q;
  assign lane_timeout     = tflag_q;
  assign grant_idx        = grant_q;
  assign busy             = (state_q != IDLE);
  assign checker_checkrdy = (state_q == STROBE);
  assign checker_hash     = hash_q;

`ifdef CHECKER_ARB_STATS_EN
  logic [31:0] check_cnt_q, check_cnt_d;
  logic [15:0] match_cnt_q, match_cnt_d;

  // Count completed checks (wrapping) and matches (saturating)
  always_comb begin
    check_cnt_d = check_cnt_q;
    match_cnt_d = match_cnt_q;
    if (state_q == REPLY) begin
      check_cnt_d = check_cnt_q + 32'd1;
      if (match_q && (match_cnt_q != 16'hFFFF)) match_cnt_d = match_cnt_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      check_cnt_q <= '0;
      match_cnt_q <= '0;
    end else begin
      check_cnt_q <= check_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign check_count = check_cnt_q;
  assign match_count = match_cnt_q;
`endif

endmodule

// File: tb/tb_checker_arbiter.sv
// Scoreboard bench for checker_arbiter: directed lane requests, a small
// hashchecker model, and a negedge monitor that pops expected replies.
module tb_checker_arbiter;
  localparam int NL  = 4;
  localparam int HW  = 128;
  localparam int TMO = 16;
  localparam int M_NORMAL = 0, M_NEVER = 1, M_STALE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0]    lane_req = '0;
  logic [NL*HW-1:0] lane_hash;
  logic [NL-1:0]    lane_done;
  logic             lane_match, lane_timeout, busy;
  logic [1:0]       grant_idx;
  logic             checker_checkrdy;
  logic [HW-1:0]    checker_hash;
  logic             chk_rr = 1'b0;
  logic             chk_mf = 1'b0;
`ifdef CHECKER_ARB_STATS_EN
  logic [31:0]      check_count;
  logic [15:0]      match_count;
`endif

  logic [HW-1:0] hashes [NL] = '{
    128'h31D6CFE0D16AE931B73C59D7E0C089C0,
    128'hA9D1CBF71942327E98B40CF5EF38A960,
    128'h8846F7EAEE8FB117AD06BDD830B7586C,
    128'h0CB6948805F797BF2A82807973B89537
  };
  assign lane_hash = {hashes[3], hashes[2], hashes[1], hashes[0]};

  checker_arbiter #(
    .NUM_LANES(NL), .HASH_W(HW), .STROBE_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .lane_req(lane_req), .lane_hash(lane_hash),
    .lane_done(lane_done), .lane_match(lane_match), .lane_timeout(lane_timeout),
    .grant_idx(grant_idx), .busy(busy), .checker_checkrdy(checker_checkrdy),
    .checker_hash(checker_hash), .checker_resultrdy(chk_rr),
    .checker_matchfound(chk_mf)
`ifdef CHECKER_ARB_STATS_EN
    , .check_count(check_count), .match_count(match_count)
`endif
  );

  typedef struct {
    int          lane;
    bit          m;
    bit          t;
    logic [HW-1:0] h;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_chk  = 0;
  int exp_mat  = 0;
  int mode     = M_NORMAL;
  logic [HW-1:0] target = '0;

  task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic push(input int lane, input bit m, input bit t, input int lat);
    exp_t e;
    e.lane = lane; e.m = m; e.t = t; e.h = hashes[lane]; e.lat = lat;
    sb.push_back(e);
    exp_chk++;
    if (m) exp_mat++;
  endtask

  // Hashchecker model: resultrdy a fixed time after checkrdy falls, or stale/never
  int   m_cnt  = -1;
  logic m_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk_rr = 1'b0; chk_mf = 1'b0; m_cnt = -1; m_prev = 1'b0;
    end else begin
      if (checker_checkrdy && !m_prev) begin
        if (mode != M_STALE) chk_rr = 1'b0;
        m_cnt = -1;
      end else if (!checker_checkrdy && m_prev) m_cnt = 0;
      else if (m_cnt >= 0) m_cnt++;
      case (mode)
        M_NORMAL: if (m_cnt >= 5) begin chk_rr = 1'b1; chk_mf = (checker_hash == target); end
        M_STALE: begin
          if (m_cnt >= 1 && m_cnt <= 3) chk_rr = 1'b0;
          else if (m_cnt >= 4) begin chk_rr = 1'b1; chk_mf = 1'b0; end
        end
        default: chk_rr = 1'b0;
      endcase
      m_prev = checker_checkrdy;
    end
  end

  // Monitor: strobe width, reply latency from DROP, and scoreboard compare
  int run_len = 0;
  int lat = -1;
  logic [NL-1:0] prev_done = '0;
  logic [NL-1:0] exp_done;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0; lat = -1; prev_done = '0;
    end else begin
      if (checker_checkrdy) begin
        run_len++; lat = -1;
      end else begin
        if (run_len != 0) begin chk("strobe_len", run_len, 2); lat = 0; end
        else if (lat >= 0) lat++;
        run_len = 0;
      end
      if (lane_done != '0) begin
        chk("done_single_cycle", prev_done, 0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got %b want none", lane_done);
        end else begin
          e = sb.pop_front();
          exp_done = NL'(1) << e.lane;
          chk("lane_done", lane_done, exp_done);
          chk("grant_idx", grant_idx, e.lane);
          chk("lane_match", lane_match, e.m);
          chk("lane_timeout", lane_timeout, e.t);
          chk("checker_hash", checker_hash, e.h);
          if (e.lat >= 0) chk("reply_latency", lat, e.lat);
        end
      end
      prev_done = lane_done;
    end
  end

  // Wait for n completions; lanes drop their request after seeing lane_done
  task automatic run(input int n, input bit sticky);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (lane_done != '0) begin
        cnt++;
        if (!sticky) lane_req = lane_req & ~lane_done;
        else if (cnt == n) lane_req = '0;
      end
    end
    if (cnt < n) begin
      n_checks++;
      $display("FAIL run_bound: got %0d dones want %0d", cnt, n);
      lane_req = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; lane_req = '0; sb.delete(); exp_chk = 0; exp_mat = 0;
    @(negedge clk);
    chk("rst_checkrdy", checker_checkrdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lane_done", lane_done, 0);
    chk("rst_match_tmo_grant", {lane_match, lane_timeout, grant_idx}, 0);
    chk("rst_checker_hash", checker_hash, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single(input int lane, input bit m);
    push(lane, m, 1'b0, 6);
    lane_req[lane] = 1'b1;
    run(1, 1'b0);
  endtask

  initial begin
    int lanes7 [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    int bound;
    do_reset();

    // Single request on lane 2, match
    mode = M_NORMAL; target = hashes[2];
    single(2, 1'b1);

    // All lanes requesting from reset: 1,2,3,0,1,2,3,0
    do_reset();
    target = hashes[3];
    for (int i = 0; i < 8; i++) push((i + 1) % NL, ((i + 1) % NL) == 3, 1'b0, 6);
    lane_req = '1;
    run(8, 1'b1);

    // Match result first, so the stale level that follows is a match
    single(3, 1'b1);
    mode = M_STALE;
    push(1, 1'b0, 1'b0, 5);
    lane_req[1] = 1'b1;
    run(1, 1'b0);

    // Timeout, then the next lane is served normally
    mode = M_NEVER;
    push(0, 1'b0, 1'b1, 17);
    lane_req[0] = 1'b1;
    run(1, 1'b0);
    mode = M_NORMAL; target = hashes[1];
    single(1, 1'b1);

    // Reset while in WAIT: no reply, pointer back to 0
    mode = M_NEVER;
    lane_req[2] = 1'b1;
    bound = 0;
    while (!checker_checkrdy && bound < 50) begin @(negedge clk); bound++; end
    while (checker_checkrdy && bound < 50) begin @(negedge clk); bound++; end
    if (bound >= 50) begin n_checks++; $display("FAIL strobe_wait: got none want strobe"); end
    repeat (3) @(negedge clk);
    do_reset();
    mode = M_NORMAL; target = hashes[0];
    single(0, 1'b1);

    // Nine more checks, three matches in total since reset
    for (int i = 0; i < 9; i++) single(lanes7[i], lanes7[i] == 0);
`ifdef CHECKER_ARB_STATS_EN
    chk("check_count", check_count, exp_chk);
    chk("match_count", match_count, exp_mat);
`endif
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
